// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues one-at-a-time word reads to instruction
// memory and buffers returned instructions, tagged with their PC, for decode.
module instr_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              inst_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] RESET_PC_AL = {RESET_PC[ADDR_W-1:2], 2'b00};

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              outstanding;
  logic              stale;

  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic              resp;
  logic              issue;
  logic              push;
  logic              pop;
  logic [CW-1:0]     occupancy;
  logic              redirect_pc_unused;

  assign redirect_pc_unused = ^redirect_pc[1:0];

  // A response only means something while a request is in flight; a late one
  // surviving a reset is ignored.
  assign resp      = imem_valid & outstanding;
  assign occupancy = count + CW'(outstanding);

  // Issue only when a queue slot is reserved for the returning word, so a
  // push can never find the queue full.
  assign issue = !reset & !redirect & (!outstanding | imem_valid) &
                 (occupancy < CW'(DEPTH));

  // Decode handshake: the head transfers on a cycle where inst_valid and
  // inst_ready are both high; inst_valid never depends on inst_ready, and a
  // redirect in the same cycle cancels the transfer.
  assign push = resp & !stale & !redirect;
  assign pop  = inst_valid & inst_ready & !redirect;

  assign imem_req   = issue;
  assign imem_addr  = fetch_pc;
  assign inst_valid = (count != '0);
  assign inst_out   = inst_valid ? inst_mem[rd_ptr] : '0;
  assign pc_out     = inst_valid ? pc_mem[rd_ptr]   : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC_AL;
      req_pc      <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= 1'b0;
      stale       <= 1'b0;
    end else if (redirect) begin
      fetch_pc    <= {redirect_pc[ADDR_W-1:2], 2'b00};
      count       <= '0;
      rd_ptr      <= wr_ptr;
      // The in-flight word belongs to the old path; mark it for dropping
      // unless it is landing right now.
      stale       <= outstanding & !imem_valid;
      outstanding <= outstanding & !imem_valid;
    end else begin
      if (issue) begin
        outstanding <= 1'b1;
        req_pc      <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_W'(4);
      end else if (resp) begin
        outstanding <= 1'b0;
      end
      if (resp) begin
        stale <= 1'b0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: in-order memory model with selectable latency,
// program-order scoreboard, a cycle table for fill/drain and redirect/reset sequences.
module tb_instr_fetch_queue;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_valid;
  logic [DW-1:0] imem_rdata;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          inst_valid;
  logic [DW-1:0] inst_out;
  logic [AW-1:0] pc_out;
  logic          inst_ready;

  logic          req2;
  logic [AW-1:0] addr2;
  logic          valid2;
  logic [DW-1:0] rdata2;
  logic          inst_valid2;
  logic [DW-1:0] inst_out2;
  logic [AW-1:0] pc_out2;

  always #5 clk = ~clk;

  instr_fetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_out(inst_out),
    .pc_out(pc_out), .inst_ready(inst_ready)
  );

  instr_fetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2),
    .imem_valid(valid2), .imem_rdata(rdata2), .redirect(1'b0),
    .redirect_pc(32'h0), .inst_valid(inst_valid2), .inst_out(inst_out2),
    .pc_out(pc_out2), .inst_ready(1'b1)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } mreq_t;

  typedef struct {
    logic          ready;
    logic          req;
    logic [AW-1:0] addr;
    logic          valid;
    logic [AW-1:0] pc;
  } vec_t;

  mreq_t         mem_q[$];
  logic [63:0]   exp_q[$];
  vec_t          vecs[$];
  logic [AW-1:0] exp_fetch;
  logic [AW-1:0] addrs2[3];
  int            n2;
  logic          prev_req2;
  int            checks;
  int            errors;
  int            cyc;
  int            mem_lat;
  int            pops;

  logic          s_req;
  logic [AW-1:0] s_addr;
  logic          s_valid;
  logic [AW-1:0] s_pc;
  logic [DW-1:0] s_inst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs after the falling edge, sample mid-cycle, score.
  task automatic step(input logic r, input logic rdy, input logic redir, input logic [AW-1:0] rpc);
    int          sz;
    logic [63:0] e;
    @(negedge clk);
    reset       = r;
    inst_ready  = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    imem_valid  = 1'b0;
    imem_rdata  = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_valid = 1'b1;
      imem_rdata = 32'h2000_0000 + mem_q[0].addr;
      void'(mem_q.pop_front());
    end
    valid2 = prev_req2;
    rdata2 = '0;
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = inst_valid;
    s_pc    = pc_out;
    s_inst  = inst_out;
    if (r) begin
      chk("rst_req", 64'(s_req), 64'd0);
      chk("rst_addr", 64'(s_addr), 64'h0);
      chk("rst_valid", 64'(s_valid), 64'd0);
      chk("rst_head", {s_pc, s_inst}, 64'h0);
      chk("rst_addr_wrap", 64'(addr2), 64'hFFFF_FFF8);
      exp_q.delete();
      exp_fetch = 32'h0;
    end else if (redir) begin
      chk("req_in_redirect", 64'(s_req), 64'd0);
      exp_q.delete();
      exp_fetch = rpc & ~32'h3;
    end else begin
      sz = exp_q.size();
      if (s_valid) begin
        chk("head_tracked", 64'(sz > 0), 64'd1);
      end else begin
        chk("idle_zero", {s_pc, s_inst}, 64'h0);
      end
      if (s_valid && rdy && sz > 0) begin
        e = exp_q.pop_front();
        chk("pop_pc", 64'(s_pc), 64'(e[63:32]));
        chk("pop_inst", 64'(s_inst), 64'(e[31:0]));
        pops++;
      end
      if (s_req) begin
        chk("req_addr", 64'(s_addr), 64'(exp_fetch));
        chk("no_overflow", 64'(sz < DEPTH), 64'd1);
        exp_q.push_back({exp_fetch, 32'h2000_0000 + exp_fetch});
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    if (s_req) mem_q.push_back('{s_addr, cyc + mem_lat});
    if (!r && req2 && n2 < 3) begin
      addrs2[n2] = addr2;
      n2++;
    end
    prev_req2 = req2 & !r;
    cyc++;
    @(posedge clk);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    logic found;
    int   p0;
    reset = 1'b1; imem_valid = 1'b0; imem_rdata = '0; redirect = 1'b0;
    redirect_pc = '0; inst_ready = 1'b0; valid2 = 1'b0; rdata2 = '0;
    checks = 0; errors = 0; cyc = 0; mem_lat = 1; pops = 0; n2 = 0;
    prev_req2 = 1'b0; exp_fetch = '0;

    // Fill with decode stalled, then drain: 1-cycle memory.
    vecs.push_back('{1'b0, 1'b1, 32'h00, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h04, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h08, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h0C, 1'b1, 32'h0});
    for (int i = 4; i < 10; i++) vecs.push_back('{1'b0, 1'b0, 32'h10, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h10, 1'b1, 32'h00});
    vecs.push_back('{1'b1, 1'b1, 32'h10, 1'b1, 32'h04});
    vecs.push_back('{1'b1, 1'b1, 32'h14, 1'b1, 32'h08});
    vecs.push_back('{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C});
    vecs.push_back('{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10});

    do_reset(3);
    for (int i = 0; i < vecs.size(); i++) begin
      step(1'b0, vecs[i].ready, 1'b0, '0);
      chk("tbl_req", 64'(s_req), 64'(vecs[i].req));
      chk("tbl_addr", 64'(s_addr), 64'(vecs[i].addr));
      chk("tbl_valid", 64'(s_valid), 64'(vecs[i].valid));
      chk("tbl_pc", 64'(s_pc), 64'(vecs[i].pc));
      chk("tbl_inst", 64'(s_inst), vecs[i].valid ? 64'(32'h2000_0000 + vecs[i].pc) : 64'h0);
    end

    chk("wrap_count", 64'(n2), 64'd3);
    chk("wrap_a0", 64'(addrs2[0]), 64'hFFFF_FFF8);
    chk("wrap_a1", 64'(addrs2[1]), 64'hFFFF_FFFC);
    chk("wrap_a2", 64'(addrs2[2]), 64'h0000_0000);

    // Sustained one instruction per cycle.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0);
    p0 = pops;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, '0);
    chk("throughput", 64'(pops - p0), 64'd8);

    // Redirect while a response lands and decode is consuming.
    chk("stream_resp_live", 64'(mem_q.size()), 64'd1);
    step(1'b0, 1'b1, 1'b1, 32'h40);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("rd1_valid", 64'(s_valid), 64'd0);
    chk("rd1_req", 64'(s_req), 64'd1);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("rd2_valid", 64'(s_valid), 64'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("rd3_valid", 64'(s_valid), 64'd1);
    chk("rd3_pc", 64'(s_pc), 64'h40);

    // Redirect with three entries queued and a 3-cycle request in flight.
    mem_lat = 3;
    do_reset(4);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, '0);
    chk("full_q", 64'(exp_q.size()), 64'd4);
    step(1'b0, 1'b0, 1'b1, 32'h103);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("stale_valid", 64'(s_valid), 64'd0);
    chk("stale_wait_req", 64'(s_req), 64'd0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("stale_req", 64'(s_req), 64'd1);
    chk("stale_addr", 64'(s_addr), 64'h100);
    p0 = pops;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, '0);
    chk("target_delivered", 64'(pops > p0), 64'd1);

    // Reset pulse while a request is outstanding; its late response must vanish.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      if (s_req && s_addr != 32'h0) found = 1'b1;
    end
    chk("outstanding_seen", 64'(found), 64'd1);
    do_reset(2);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("late_resp_present", 64'(imem_valid), 64'd1);
    chk("restart_req", 64'(s_req), 64'd1);
    chk("restart_addr", 64'(s_addr), 64'h0);
    p0 = pops;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, '0);
    chk("restart_delivered", 64'(pops > p0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
